// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and FSM state encoding for mem_arbiter
package mem_arbiter_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client request channels plus memory-side strobes for mem_arbiter
// slave  : arbiter view (rqN_req/we/addr/wdata and mem_r_data in; rqN_gnt/rvalid/rdata and mem_* strobes out)
// master : client/memory view with the directions mirrored
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic              rq0_req, rq0_we, rq0_gnt, rq0_rvalid;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata, rq0_rdata;
    logic              rq1_req, rq1_we, rq1_gnt, rq1_rvalid;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata, rq1_rdata;
    logic              mem_w_en, mem_r_en;
    logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
    logic [DATA_W-1:0] mem_w_data, mem_r_data;
    modport slave (
        input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
        input  mem_r_data,
        output rq0_gnt, rq0_rvalid, rq0_rdata,
        output rq1_gnt, rq1_rvalid, rq1_rdata,
        output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );
    modport master (
        output rq0_req, rq0_we, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_addr, rq1_wdata,
        output mem_r_data,
        input  rq0_gnt, rq0_rvalid, rq0_rdata,
        input  rq1_gnt, rq1_rvalid, rq1_rdata,
        input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker with a registered priority pointer
// Ports: clk, rst_n (async, active low), req[1:0] requests, advance (a grant is
//        being taken this cycle), gnt_onehot[1:0] combinational winner
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_onehot
);
    logic ptr;
    // ptr names the client that wins a conflict; a lone requester always wins
    assign gnt_onehot = &req ? (ptr ? 2'b10 : 2'b01) : req;
    // after a grant, priority passes to the client that did not win
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance)
            ptr <= gnt_onehot[0];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter and sequencer in front of a 16x8 dual-port memory
// Ports: clk, rst_n (async, active low); bus (slave) carries both client
//        req/gnt/rvalid/rdata channels and the memory strobe/address/data lines
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    state_t            state;
    logic [1:0]        req, pick, gnt, rvalid;
    logic              advance, sel_we, w_en, r_en;
    logic [ADDR_W-1:0] sel_addr, w_addr, r_addr;
    logic [DATA_W-1:0] sel_wdata, w_data;

    assign req       = {bus.rq1_req, bus.rq0_req};
    assign advance   = state == S_IDLE && |req;
    assign sel_we    = pick[1] ? bus.rq1_we    : bus.rq0_we;
    assign sel_addr  = pick[1] ? bus.rq1_addr  : bus.rq0_addr;
    assign sel_wdata = pick[1] ? bus.rq1_wdata : bus.rq0_wdata;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (advance),
        .gnt_onehot(pick)
    );

    // the memory strobe registers double as the capture of the winner's request;
    // every pulse defaults low so it lasts exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            gnt    <= '0;
            rvalid <= '0;
            w_en   <= 1'b0;
            r_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            r_addr <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            w_en   <= 1'b0;
            r_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            r_addr <= '0;
            case (state)
                S_IDLE: if (advance) begin
                    state  <= S_ISSUE;
                    gnt    <= pick;
                    w_en   <= sel_we;
                    r_en   <= !sel_we;
                    w_addr <= sel_we ? sel_addr : '0;
                    w_data <= sel_we ? sel_wdata : '0;
                    r_addr <= sel_we ? '0 : sel_addr;
                end
                S_ISSUE: begin
                    state  <= r_en ? S_RD_WAIT : S_IDLE;
                    rvalid <= r_en ? gnt : 2'b00;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rq0_gnt    = gnt[0];
    assign bus.rq1_gnt    = gnt[1];
    assign bus.rq0_rvalid = rvalid[0];
    assign bus.rq1_rvalid = rvalid[1];
    assign bus.rq0_rdata  = bus.mem_r_data;
    assign bus.rq1_rdata  = bus.mem_r_data;
    assign bus.mem_w_en   = w_en;
    assign bus.mem_w_addr = w_addr;
    assign bus.mem_w_data = w_data;
    assign bus.mem_r_en   = r_en;
    assign bus.mem_r_addr = r_addr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural 16x8 memory
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
    } txn_t;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] rv;
        logic       wen;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [3:0] raddr;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    txn_t       q0[$], q1[$];
    logic       act0 = 1'b0, act1 = 1'b0;
    int         glog[$], gcyc[$];
    logic [7:0] rd0[$], rd1[$];
    logic [7:0] mem[16];
    logic [7:0] shadow[16];
    logic [7:0] mem_rd = 8'h00;
    exp_t       e = '0;
    int         m_busy = 0;
    logic       m_ptr = 1'b0;
    logic [1:0] m_pv = 2'b00;
    logic [7:0] m_pd = 8'h00;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory stand-in: preload value of word i is 0xC0+i, registered read
    initial for (int i = 0; i < 16; i++) begin
        mem[i] = 8'(8'hC0 + i);
        shadow[i] = 8'(8'hC0 + i);
    end
    always @(posedge clk) begin
        if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_w_data;
        if (bus.mem_r_en) mem_rd <= mem[bus.mem_r_addr];
    end
    assign bus.mem_r_data = mem_rd;

    // transaction-slot model: an idle arbiter takes one request per edge, then is
    // busy for 1 cycle (write) or 2 cycles (read); reads return the shadow contents
    // as of grant time, one cycle after the strobe
    always @(posedge clk or negedge rst_n) begin : model
        exp_t       n;
        int         w;
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        n = '0;
        if (!rst_n) begin
            e      <= '0;
            m_busy <= 0;
            m_ptr  <= 1'b0;
            m_pv   <= 2'b00;
        end else begin
            n.rv    = m_pv;
            n.rdata = m_pd;
            m_pv   <= 2'b00;
            if (m_busy > 0)
                m_busy <= m_busy - 1;
            else if (bus.rq0_req || bus.rq1_req) begin
                w  = (bus.rq0_req && bus.rq1_req) ? int'(m_ptr) : int'(bus.rq1_req);
                we = w == 1 ? bus.rq1_we : bus.rq0_we;
                a  = w == 1 ? bus.rq1_addr : bus.rq0_addr;
                d  = w == 1 ? bus.rq1_wdata : bus.rq0_wdata;
                m_ptr <= w == 0;
                n.gnt = w == 1 ? 2'b10 : 2'b01;
                if (we) begin
                    n.wen     = 1'b1;
                    n.waddr   = a;
                    n.wdata   = d;
                    shadow[a] <= d;
                    m_busy    <= 1;
                end else begin
                    n.ren   = 1'b1;
                    n.raddr = a;
                    m_pv   <= n.gnt;
                    m_pd   <= shadow[a];
                    m_busy <= 2;
                end
            end
            e <= n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, {30'd0, e.gnt});
        chk("rvalid", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, {30'd0, e.rv});
        chk("mem_w_en", bus.mem_w_en, e.wen);
        chk("mem_w_addr", bus.mem_w_addr, e.waddr);
        chk("mem_w_data", bus.mem_w_data, e.wdata);
        chk("mem_r_en", bus.mem_r_en, e.ren);
        chk("mem_r_addr", bus.mem_r_addr, e.raddr);
        if (e.rv[0]) chk("rq0_rdata", bus.rq0_rdata, e.rdata);
        if (e.rv[1]) chk("rq1_rdata", bus.rq1_rdata, e.rdata);
    end

    // client agents: hold each queued request until its grant, then present the next
    initial begin
        txn_t t;
        bus.rq0_req = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
        bus.rq1_req = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.rq0_gnt) begin glog.push_back(0); gcyc.push_back(cyc); end
            if (bus.rq1_gnt) begin glog.push_back(1); gcyc.push_back(cyc); end
            if (bus.rq0_rvalid) rd0.push_back(bus.rq0_rdata);
            if (bus.rq1_rvalid) rd1.push_back(bus.rq1_rdata);
            if (!rst_n) begin
                act0 = 1'b0;
                act1 = 1'b0;
            end else begin
                if (bus.rq0_gnt) act0 = 1'b0;
                if (bus.rq1_gnt) act1 = 1'b0;
                if (!act0 && q0.size() > 0) begin
                    t = q0.pop_front();
                    bus.rq0_we = t.we; bus.rq0_addr = t.a; bus.rq0_wdata = t.d;
                    act0 = 1'b1;
                end
                if (!act1 && q1.size() > 0) begin
                    t = q1.pop_front();
                    bus.rq1_we = t.we; bus.rq1_addr = t.a; bus.rq1_wdata = t.d;
                    act1 = 1'b1;
                end
            end
            bus.rq0_req = act0;
            bus.rq1_req = act1;
        end
    end

    task automatic push(input int k, input logic we, input logic [3:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.a = a; t.d = d;
        if (k == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int k);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = k == 0 ? bus.rq0_gnt : bus.rq1_gnt;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL wait_gnt%0d: no grant, expected one within 20 cycles", k);
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge clk);
            #1;
            quiet = (q0.size() == 0 && q1.size() == 0 && !act0 && !act1 && !bus.mem_w_en &&
                     !bus.mem_r_en && !bus.rq0_rvalid && !bus.rq1_rvalid) ? quiet + 1 : 0;
        end
        if (quiet < 4) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle: still busy, expected idle within 400 cycles");
        end
    endtask

    initial begin
        int n0;
        int z;
        // 1: reset state, then quiet bus
        repeat (3) @(negedge clk);
        chk("t1_rst_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 0);
        chk("t1_rst_rvalid", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 0);
        chk("t1_rst_strobes", {30'd0, bus.mem_w_en, bus.mem_r_en}, 0);
        chk("t1_rst_addr_data", {16'd0, bus.mem_w_addr, bus.mem_r_addr, bus.mem_w_data}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_no_grant", glog.size(), 0);
        // 2: client 0 reads addr 3
        sync();
        push(0, 1'b0, 4'd3, 8'h00);
        wait_gnt(0);
        chk("t2_r_en", bus.mem_r_en, 1);
        chk("t2_r_addr", bus.mem_r_addr, 3);
        @(negedge clk);
        chk("t2_rvalid", bus.rq0_rvalid, 1);
        chk("t2_rdata", bus.rq0_rdata, 8'hC3);
        wait_idle();
        // 3: simultaneous write 0x0F<=0xA5 (client 0) and read 0x0F (client 1)
        reset_pulse();
        sync();
        glog.delete();
        rd1.delete();
        push(0, 1'b1, 4'hF, 8'hA5);
        push(1, 1'b0, 4'hF, 8'h00);
        wait_idle();
        chk("t3_grants", glog.size(), 2);
        chk("t3_first", glog[0], 0);
        chk("t3_second", glog[1], 1);
        chk("t3_rd_count", rd1.size(), 1);
        chk("t3_rdata", rd1[0], 8'hA5);
        // 4: both clients stream reads, 12 grants alternate without gaps
        reset_pulse();
        sync();
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 1'b0, 4'(i), 8'h00);
            push(1, 1'b0, 4'(8 + i), 8'h00);
        end
        wait_idle();
        chk("t4_grants", glog.size(), 12);
        for (int i = 0; i < 12; i++) chk("t4_order", glog[i], i % 2);
        for (int i = 0; i < 11; i++) chk("t4_spacing", gcyc[i + 1] - gcyc[i], 3);
        // 5: reset during RD_WAIT drops the read; pointer returns to client 0
        sync();
        push(0, 1'b0, 4'd5, 8'h00);
        wait_gnt(0);
        @(negedge clk);
        chk("t5_rvalid_before", bus.rq0_rvalid, 1);
        chk("t5_rdata_before", bus.rq0_rdata, 8'hC5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid_drop", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 0);
        chk("t5_strobe_drop", {30'd0, bus.mem_w_en, bus.mem_r_en}, 0);
        n0 = rd0.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_late_rvalid", rd0.size(), n0);
        sync();
        glog.delete();
        push(0, 1'b0, 4'd1, 8'h00);
        push(1, 1'b0, 4'd2, 8'h00);
        wait_idle();
        chk("t5_first_after_rst", glog[0], 0);
        // 6: client 1 alone writes then reads back all 16 words
        reset_pulse();
        sync();
        glog.delete();
        rd0.delete();
        rd1.delete();
        for (int i = 0; i < 16; i++) push(1, 1'b1, 4'(i), 8'(8'h10 + i));
        for (int i = 0; i < 16; i++) push(1, 1'b0, 4'(i), 8'h00);
        wait_idle();
        chk("t6_rd_count", rd1.size(), 16);
        for (int i = 0; i < 16; i++) chk("t6_rdata", rd1[i], 8'(8'h10 + i));
        z = 0;
        foreach (glog[i]) if (glog[i] == 0) z++;
        chk("t6_grants", glog.size(), 32);
        chk("t6_no_gnt0", z, 0);
        chk("t6_no_rvalid0", rd0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run still active, expected completion before 400000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
